id_decode_front: RTL and testbench

- Fetch/decode front end for the SPARC-subset pipeline.
- Contains a byte-addressed instruction memory with a combinational 32-bit big-endian read at the PC, and the IF/ID instruction latch.
- Also contains the ID-stage control decoder, and a hazard mux that forces the pipelined control signals to zero (bubble) when S=1.
- Feeds the ID/EX pipeline register.

---
 rtl/id_decode_front_pkg.sv | 51 +++++
 rtl/id_decode_front_if.sv | 41 ++++
 rtl/id_ctrl_decode.sv | 65 ++++++
 rtl/id_decode_front.sv | 66 ++++++
 tb/tb_id_decode_front.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/id_decode_front_pkg.sv
// Shared encodings for the SPARC-subset fetch/decode front end: instruction
// field codes, data-memory size codes and the decoded control bundle.
package id_decode_front_pkg;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_JMPL    = 6'b111000;
    localparam logic [5:0] OP3_SAVE    = 6'b111100;
    localparam logic [5:0] OP3_RESTORE = 6'b111101;

    localparam logic [5:0] ALU_ADD      = 6'b000000;
    localparam logic [5:0] ALU_PASS_IMM = 6'b100110;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'b00,
        SIZE_HALF  = 2'b01,
        SIZE_WORD  = 2'b10,
        SIZE_DWORD = 2'b11
    } size_dm_e;

    typedef struct packed {
        logic       b_instr;
        logic       annul;
        logic       jmpl;
        logic       rw;
        logic       se_dm;
        logic       load;
        logic       rf_en;
        logic       modcc;
        logic       call;
        size_dm_e   size_dm;
        logic [5:0] alu_op3;
    } id_ctrl_t;

    // Memory op3[1:0] does not follow size order: 00 is a word access.
    function automatic size_dm_e mem_size(input logic [1:0] op3_lo);
        case (op3_lo)
            2'b01:   mem_size = SIZE_BYTE;
            2'b10:   mem_size = SIZE_HALF;
            2'b00:   mem_size = SIZE_WORD;
            default: mem_size = SIZE_DWORD;
        endcase
    endfunction

endpackage

// File: rtl/id_decode_front_if.sv
// Fetch/decode bus: IF/ID control, instruction-memory preload port and the
// decoded (raw and hazard-muxed) control outputs.
interface id_decode_front_if #(
    parameter int ADDR_W = 8
);
    logic              LE;
    logic [ADDR_W-1:0] pc;
    logic              S;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    logic [31:0]       if_instr;
    logic [31:0]       id_instr;
    logic [5:0]        ID_ALU_op3;
    logic              ID_B_instr;
    logic              ID_29_a;
    logic              jmpl_o;
    logic              rw_o;
    logic              se_dm_o;
    logic              load_o;
    logic              rf_en_o;
    logic              modcc_o;
    logic              call_o;
    logic [1:0]        size_dm_o;
    logic [5:0]        alu_op3_o;

    modport master (
        output LE, pc, S, mem_we, mem_waddr, mem_wdata,
        input  if_instr, id_instr, ID_ALU_op3, ID_B_instr, ID_29_a,
               jmpl_o, rw_o, se_dm_o, load_o, rf_en_o, modcc_o, call_o,
               size_dm_o, alu_op3_o
    );

    modport slave (
        input  LE, pc, S, mem_we, mem_waddr, mem_wdata,
        output if_instr, id_instr, ID_ALU_op3, ID_B_instr, ID_29_a,
               jmpl_o, rw_o, se_dm_o, load_o, rf_en_o, modcc_o, call_o,
               size_dm_o, alu_op3_o
    );
endinterface

// File: rtl/id_ctrl_decode.sv
// ID-stage control decoder: purely combinational map from the latched
// instruction word to the pipeline control bundle.
module id_ctrl_decode
    import id_decode_front_pkg::*;
(
    input  logic [31:0] instr,
    output id_ctrl_t    ctrl
);

    logic [1:0] op;
    logic [2:0] op2;
    logic [5:0] op3;
    logic       unused_fields;

    assign op  = instr[31:30];
    assign op2 = instr[24:22];
    assign op3 = instr[24:19];
    assign unused_fields = ^{instr[28:25], instr[18:0]};

    // NOTE: every field gets a default before the case so no path leaves a
    // control bit unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl = '0;
        case (op)
            OP_CALL: begin
                ctrl.call  = 1'b1;
                ctrl.rf_en = 1'b1;
            end
            OP_BRANCH: begin
                if (op2 == OP2_BICC) begin
                    ctrl.b_instr = 1'b1;
                    ctrl.annul   = instr[29];
                end else if (op2 == OP2_SETHI) begin
                    ctrl.rf_en   = 1'b1;
                    ctrl.alu_op3 = ALU_PASS_IMM;
                end
            end
            OP_ARITH: begin
                ctrl.rf_en = 1'b1;
                if (op3 == OP3_JMPL) begin
                    ctrl.jmpl    = 1'b1;
                    ctrl.alu_op3 = ALU_ADD;
                end else if (op3 == OP3_SAVE || op3 == OP3_RESTORE) begin
                    ctrl.alu_op3 = ALU_ADD;
                end else begin
                    ctrl.alu_op3 = op3;
                    ctrl.modcc   = ~op3[5] & op3[4];
                end
            end
            OP_MEM: begin
                ctrl.alu_op3 = ALU_ADD;
                ctrl.size_dm = mem_size(op3[1:0]);
                if (op3[2]) begin
                    ctrl.rw = 1'b1;
                end else begin
                    ctrl.load  = 1'b1;
                    ctrl.rf_en = 1'b1;
                    ctrl.se_dm = op3[3];
                end
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/id_decode_front.sv
// Fetch/decode front end: byte-addressed instruction memory, IF/ID latch,
// control decoder and the bubble mux feeding ID/EX.
module id_decode_front
    import id_decode_front_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
)(
    input logic               Clk,
    input logic               R,
    id_decode_front_if.slave  bus
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] addr1, addr2, addr3;
    logic [31:0]       id_instr_q;
    id_ctrl_t          dec;

    // Byte addresses wrap naturally at the ADDR_W boundary.
    assign addr1 = bus.pc + ADDR_W'(1);
    assign addr2 = bus.pc + ADDR_W'(2);
    assign addr3 = bus.pc + ADDR_W'(3);

    assign bus.if_instr = {mem[bus.pc], mem[addr1], mem[addr2], mem[addr3]};

    // NOTE: the instruction store has no reset; its contents come only from
    // the preload port, so R leaves it untouched.
    always_ff @(posedge Clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_waddr] <= bus.mem_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk) begin
        if (R) begin
            id_instr_q <= '0;
        end else if (bus.LE) begin
            id_instr_q <= bus.if_instr;
        end
    end

    assign bus.id_instr = id_instr_q;

    id_ctrl_decode u_decode (
        .instr (id_instr_q),
        .ctrl  (dec)
    );

    assign bus.ID_ALU_op3 = dec.alu_op3;
    assign bus.ID_B_instr = dec.b_instr;
    assign bus.ID_29_a    = dec.annul;

    // Bubble: S squashes everything that travels on into ID/EX.
    assign bus.jmpl_o    = dec.jmpl  & ~bus.S;
    assign bus.rw_o      = dec.rw    & ~bus.S;
    assign bus.se_dm_o   = dec.se_dm & ~bus.S;
    assign bus.load_o    = dec.load  & ~bus.S;
    assign bus.rf_en_o   = dec.rf_en & ~bus.S;
    assign bus.modcc_o   = dec.modcc & ~bus.S;
    assign bus.call_o    = dec.call  & ~bus.S;
    assign bus.size_dm_o = bus.S ? 2'b00 : dec.size_dm;
    assign bus.alu_op3_o = bus.S ? 6'b000000 : dec.alu_op3;

endmodule

// File: tb/tb_id_decode_front.sv
// Self-checking bench for id_decode_front: directed steps from the decode
// table plus randomized fetch/decode against a behavioural model.
module tb_id_decode_front;

    logic Clk;
    logic R;
    int   checks;
    int   failures;

    id_decode_front_if #(.ADDR_W(8)) bus ();

    id_decode_front dut (
        .Clk (Clk),
        .R   (R),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic [5:0] alu;
        logic       b;
        logic       a;
        logic       jmpl;
        logic       rw;
        logic       se;
        logic       load;
        logic       rf;
        logic       modcc;
        logic       call;
        logic [1:0] size;
    } exp_t;

    // Size codes indexed by op3[1:0]: word, byte, half, double.
    localparam logic [7:0] SIZE_LUT = {2'b11, 2'b01, 2'b00, 2'b10};

    logic [7:0]  model_mem [256];
    logic [31:0] exp_id;

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        int         op, op2, op3;
        op  = int'(w[31:30]);
        op2 = int'(w[24:22]);
        op3 = int'(w[24:19]);
        e = '0;
        if (op == 1) begin
            e.call = 1'b1;
            e.rf   = 1'b1;
        end else if (op == 0) begin
            if (op2 == 2) begin
                e.b = 1'b1;
                e.a = w[29];
            end else if (op2 == 4) begin
                e.rf  = 1'b1;
                e.alu = 6'd38;
            end
        end else if (op == 2) begin
            e.rf = 1'b1;
            if (op3 == 56) begin
                e.jmpl = 1'b1;
            end else if (op3 != 60 && op3 != 61) begin
                e.alu   = w[24:19];
                e.modcc = (op3 >= 16 && op3 < 32);
            end
        end else begin
            e.size = SIZE_LUT[2*int'(w[20:19]) +: 2];
            if (w[21]) begin
                e.rw = 1'b1;
            end else begin
                e.load = 1'b1;
                e.rf   = 1'b1;
                e.se   = w[22];
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        return {model_mem[a], model_mem[8'(a + 8'd1)],
                model_mem[8'(a + 8'd2)], model_mem[8'(a + 8'd3)]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] w,
                                 input logic s);
        exp_t e;
        e = ref_decode(w);
        check({tag, ".id_instr"},   bus.id_instr, w);
        check({tag, ".ID_ALU_op3"}, 32'(bus.ID_ALU_op3), 32'(e.alu));
        check({tag, ".ID_B_instr"}, 32'(bus.ID_B_instr), 32'(e.b));
        check({tag, ".ID_29_a"},    32'(bus.ID_29_a), 32'(e.a));
        check({tag, ".jmpl_o"},     32'(bus.jmpl_o),  32'(e.jmpl & ~s));
        check({tag, ".rw_o"},       32'(bus.rw_o),    32'(e.rw & ~s));
        check({tag, ".se_dm_o"},    32'(bus.se_dm_o), 32'(e.se & ~s));
        check({tag, ".load_o"},     32'(bus.load_o),  32'(e.load & ~s));
        check({tag, ".rf_en_o"},    32'(bus.rf_en_o), 32'(e.rf & ~s));
        check({tag, ".modcc_o"},    32'(bus.modcc_o), 32'(e.modcc & ~s));
        check({tag, ".call_o"},     32'(bus.call_o),  32'(e.call & ~s));
        check({tag, ".size_dm_o"},  32'(bus.size_dm_o), s ? 32'd0 : 32'(e.size));
        check({tag, ".alu_op3_o"},  32'(bus.alu_op3_o), s ? 32'd0 : 32'(e.alu));
    endtask

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        bus.mem_we    = 1'b1;
        bus.mem_waddr = a;
        bus.mem_wdata = d;
        @(posedge Clk);
        #1;
        bus.mem_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] w);
        write_byte(a,                w[31:24]);
        write_byte(8'(a + 8'd1),     w[23:16]);
        write_byte(8'(a + 8'd2),     w[15:8]);
        write_byte(8'(a + 8'd3),     w[7:0]);
    endtask

    task automatic load_word(input string tag, input logic [31:0] w);
        write_word(8'h00, w);
        bus.pc = 8'h00;
        bus.LE = 1'b1;
        @(posedge Clk);
        #1;
        bus.LE = 1'b0;
        exp_id = w;
        check_outputs(tag, w, 1'b0);
    endtask

    initial begin
        logic [7:0]  base;
        logic [31:0] w;
        logic        le;
        logic        s;

        checks        = 0;
        failures      = 0;
        R             = 1'b1;
        bus.LE        = 1'b0;
        bus.pc        = 8'h00;
        bus.S         = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_waddr = 8'h00;
        bus.mem_wdata = 8'h00;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

        // Reset has priority over LE even with a live word at pc.
        write_word(8'h00, 32'h82006005);
        bus.LE = 1'b1;
        @(posedge Clk);
        #1;
        check("reset.if_instr", bus.if_instr, 32'h82006005);
        check_outputs("reset", 32'h0, 1'b0);

        R      = 1'b0;
        bus.LE = 1'b0;
        @(posedge Clk);
        #1;
        check_outputs("reset_hold", 32'h0, 1'b0);

        load_word("add", 32'h82006005);
        check("add.rf_const", 32'(bus.rf_en_o), 32'd1);

        load_word("subcc", 32'h80A06001);
        check("subcc.alu_const",   32'(bus.alu_op3_o), 32'h14);
        check("subcc.modcc_const", 32'(bus.modcc_o), 32'd1);

        bus.S = 1'b1;
        #1;
        check_outputs("bubble_subcc", 32'h80A06001, 1'b1);
        check("bubble_subcc.raw_alu", 32'(bus.ID_ALU_op3), 32'h14);
        bus.S = 1'b0;

        load_word("ldub", 32'hC2086000);
        check("ldub.load_const", 32'(bus.load_o), 32'd1);
        load_word("ldsb", 32'hC2486000);
        check("ldsb.se_const", 32'(bus.se_dm_o), 32'd1);
        load_word("st", 32'hC2206000);
        check("st.size_const", 32'(bus.size_dm_o), 32'd2);

        load_word("ba_a", 32'h30800002);
        bus.S = 1'b1;
        #1;
        check_outputs("bubble_ba_a", 32'h30800002, 1'b1);
        check("bubble_ba_a.B_const", 32'(bus.ID_B_instr), 32'd1);
        bus.S = 1'b0;

        load_word("call", 32'h40000004);
        check("call.call_const", 32'(bus.call_o), 32'd1);
        load_word("jmpl", 32'h81C3E008);
        check("jmpl.jmpl_const", 32'(bus.jmpl_o), 32'd1);
        load_word("save", 32'h9DE3BF98);

        load_word("bubble_add", 32'h82006005);
        bus.S = 1'b1;
        #1;
        check_outputs("bubble_add", 32'h82006005, 1'b1);
        bus.S = 1'b0;

        // LE low holds the latch while pc moves.
        bus.pc = 8'h40;
        @(posedge Clk);
        #1;
        check_outputs("le_hold", 32'h82006005, 1'b0);

        // Fetch across the top of the address space.
        write_byte(8'hFE, 8'h11);
        write_byte(8'hFF, 8'h22);
        write_byte(8'h00, 8'h33);
        write_byte(8'h01, 8'h44);
        bus.pc = 8'hFE;
        #1;
        check("wrap.if_instr", bus.if_instr, 32'h11223344);
        bus.LE = 1'b1;
        @(posedge Clk);
        #1;
        bus.LE = 1'b0;
        exp_id = 32'h11223344;
        check_outputs("wrap_sethi", 32'h11223344, 1'b0);
        check("wrap_sethi.alu_const", 32'(bus.ID_ALU_op3), 32'h26);

        for (int i = 0; i < 48; i++) begin
            base = 8'($urandom_range(0, 255));
            w    = $urandom;
            write_word(base, w);
            bus.pc = base;
            le     = 1'($urandom_range(0, 1));
            s      = 1'($urandom_range(0, 1));
            #1;
            check("rand.if_instr", bus.if_instr, model_read(base));
            bus.LE = le;
            bus.S  = s;
            @(posedge Clk);
            #1;
            if (le) exp_id = model_read(base);
            check_outputs("rand", exp_id, s);
            bus.LE = 1'b0;
            bus.S  = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
